// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer: lane steering, byte enables, load extension,
// misalignment detection and a wait-state handshake with timeout.
// Ports: clk/reset; req_* request from datapath; mem_* data-memory bus;
// busy (core stall), done (1-cycle pulse), rdata (load result), err.
module mem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  // Request decode (IDLE side)
  logic        req_mis;
  logic [3:0]  req_be;
  logic [31:0] req_wrep;

  always_comb begin
    req_mis  = 1'b0;
    req_be   = 4'b0000;
    req_wrep = req_wdata;
    case (req_size)
      2'b00: begin
        req_be   = 4'b0001 << req_addr[1:0];
        req_wrep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_mis  = req_addr[0];
        req_be   = req_addr[1] ? 4'b1100 : 4'b0011;
        req_wrep = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        req_mis  = |req_addr[1:0];
        req_be   = 4'b1111;
      end
      default: req_mis = 1'b1;
    endcase
  end

  // Load extraction from the captured address/size
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data;

  always_comb begin
    ld_b    = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_h    = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_data = mem_rdata;
    case (size_q)
      2'b00:   ld_data = {{24{ld_b[7] & ~uns_q}}, ld_b};
      2'b01:   ld_data = {{16{ld_h[15] & ~uns_q}}, ld_h};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          be_d    = req_be;
          wdata_d = req_wrep;
          err_d   = req_mis;
          cnt_d   = '0;
          state_d = req_mis ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          err_d   = 1'b0;
          state_d = DONE;
          if (!we_q) rdata_d = ld_data;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // last allowed wait cycle has elapsed without ack
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_req   = (state_q == ACCESS);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = done & err_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (TIMEOUT=4).
// Drives/samples on the falling edge; expectations are hand-computed.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        busy, done, err;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_ctrl #(.TIMEOUT(4), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .busy(busy),
    .done(done), .rdata(rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Observations from one access
  int          o_done, o_reqc, o_err, o_we;
  logic [31:0] o_addr, o_wdata;
  logic [3:0]  o_be;

  // ack_at: cycle in which mem_ack is high (0 = never)
  task automatic run(input logic we, input logic [1:0] sz,
                     input logic uns, input logic [31:0] a,
                     input logic [31:0] wd, input int ack_at,
                     input logic [31:0] rd);
    o_done = -1; o_reqc = 0; o_err = -1; o_we = 0;
    o_addr = '0; o_wdata = '0; o_be = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz;
    req_unsigned = uns; req_addr = a; req_wdata = wd;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      mem_ack = 1'b0;
      if (mem_req) begin
        o_reqc++;
        o_addr = mem_addr; o_be = mem_be;
        o_wdata = mem_wdata; o_we = int'(mem_we);
      end
      if (done) begin
        o_done = c; o_err = int'(err);
        break;
      end
      mem_ack = (c == ack_at);
      mem_rdata = rd;
    end
    mem_ack = 1'b0;
    @(negedge clk);
  endtask

  int bad_done;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_be", {28'b0, mem_be}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    reset = 1'b0;

    // lb @3, zero-wait
    run(1'b0, 2'b00, 1'b0, 32'h3, 32'h0, 1, 32'h80FF1234);
    chk("lb_be", {28'b0, o_be}, 32'h8);
    chk("lb_done", o_done, 2);
    chk("lb_err", o_err, 0);
    chk("lb_rdata", rdata, 32'hFFFFFF80);
    chk("lb_reqc", o_reqc, 1);
    chk("lb_idle", {31'b0, busy}, 32'd0);

    run(1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 1, 32'h8001ABCD);
    chk("lh_rdata", rdata, 32'hFFFF8001);
    chk("lh_be", {28'b0, o_be}, 32'hC);
    run(1'b0, 2'b01, 1'b1, 32'h2, 32'h0, 1, 32'h8001ABCD);
    chk("lhu_rdata", rdata, 32'h00008001);
    run(1'b0, 2'b01, 1'b0, 32'h0, 32'h0, 1, 32'h12347FFF);
    chk("lh0_rdata", rdata, 32'h00007FFF);
    chk("lh0_be", {28'b0, o_be}, 32'h3);

    // sb @5, three wait cycles
    run(1'b1, 2'b00, 1'b0, 32'h5, 32'h000000A5, 4, 32'hFFFFFFFF);
    chk("sb_addr", o_addr, 32'h4);
    chk("sb_be", {28'b0, o_be}, 32'h2);
    chk("sb_wdata", o_wdata, 32'hA5A5A5A5);
    chk("sb_we", o_we, 1);
    chk("sb_reqc", o_reqc, 4);
    chk("sb_done", o_done, 5);
    chk("sb_rdata", rdata, 32'h00007FFF);

    // sh @6
    run(1'b1, 2'b01, 1'b0, 32'h6, 32'h1234ABCD, 2, 32'h0);
    chk("sh_wdata", o_wdata, 32'hABCDABCD);
    chk("sh_be", {28'b0, o_be}, 32'hC);
    chk("sh_done", o_done, 3);

    // lw @8, one wait
    run(1'b0, 2'b10, 1'b1, 32'h8, 32'h0, 2, 32'hDEADBEEF);
    chk("lw_rdata", rdata, 32'hDEADBEEF);
    chk("lw_be", {28'b0, o_be}, 32'hF);
    chk("lw_we", o_we, 0);
    chk("lw_done", o_done, 3);

    // misaligned
    run(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 1, 32'h0);
    chk("mlw_reqc", o_reqc, 0);
    chk("mlw_done", o_done, 1);
    chk("mlw_err", o_err, 1);
    run(1'b0, 2'b01, 1'b0, 32'h1, 32'h0, 1, 32'h0);
    chk("mlh_reqc", o_reqc, 0);
    chk("mlh_done", o_done, 1);
    chk("mlh_err", o_err, 1);
    run(1'b1, 2'b11, 1'b0, 32'h0, 32'h0, 1, 32'h0);
    chk("msz_err", o_err, 1);

    // timeout
    run(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 32'h11111111);
    chk("to_reqc", o_reqc, 4);
    chk("to_done", o_done, 5);
    chk("to_err", o_err, 1);
    chk("to_rdata", rdata, 32'hDEADBEEF);

    // reset in cycle 2 of an access
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10;
    req_addr = 32'h20;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mr_req", {31'b0, mem_req}, 32'd0);
    chk("mr_busy", {31'b0, busy}, 32'd0);
    bad_done = int'(done);
    repeat (4) begin
      @(negedge clk);
      bad_done += int'(done);
    end
    chk("mr_nodone", bad_done, 0);

    // lbu @1 after reset
    run(1'b0, 2'b00, 1'b1, 32'h1, 32'h0, 1, 32'h0000C300);
    chk("lbu_rdata", rdata, 32'h000000C3);
    chk("lbu_done", o_done, 2);
    chk("lbu_err", o_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences data-memory loads/stores for the MIPS core: sub-word lane extraction, byte-enable generation, sign/zero extension of loaded bytes/halfwords, misalignment detection, and wait-state handshake with a timeout.
- Sits between the datapath (ALU address, rt store data) and the data memory.
- The core stalls on busy.

Parameters:
- TIMEOUT, 16: max cycles waiting for mem_ack before aborting with error (must be >= 1).
- ADDR_W, 32: byte-address width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  access request, sampled only in IDLE
- req_we  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as misaligned)
- req_unsigned  in  1  1=zero-extend load (lbu/lhu), 0=sign-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- mem_req  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  word-aligned address ({req_addr[ADDR_W-1:2],2'b00})
- mem_be  out  4  byte enables, little-endian lanes
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completion, valid only while mem_req=1
- mem_rdata  in  32  read word, valid with mem_ack
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load result, held until next done
- err  out  1  valid with done: misaligned or timeout

Behaviour:
- Reset (synchronous):
  - State -> IDLE; timeout counter -> 0.
  - mem_req, mem_we, mem_be, done, err, busy -> 0; mem_addr, mem_wdata, rdata -> 0.
  - Reset overrides every state, including mid-access: mem_req drops the next cycle and no done is produced.
- States: IDLE, ACCESS, DONE.
- IDLE, req_valid=1:
  - Capture req_* into internal registers.
  - Aligned request -> ACCESS.
  - Misaligned request (half with addr[0]=1, word with addr[1:0]!=0, size=11) -> DONE with err=1; no mem_req is ever issued.
- ACCESS:
  - mem_req=1; mem_addr, mem_we, mem_be, mem_wdata are driven from captured registers and stay stable.
  - Timeout counter increments each cycle with mem_ack=0.
  - mem_ack=1 -> DONE; for a load, rdata is captured at that edge.
  - Counter reaching TIMEOUT with no ack -> DONE with err=1; mem_req drops; rdata is unchanged.
- DONE: done=1 for exactly one cycle, err valid, then -> IDLE. req_valid is ignored in DONE.
- Latency:
  - Request accepted at cycle 0; mem_req rises at cycle 1.
  - Ack at cycle k -> done at cycle k+1.
  - Zero-wait memory (ack at cycle 1) -> done at cycle 2.
  - Misaligned -> done at cycle 1.
- Byte enables (lane = addr[1:0]):
  - Byte: be=1<<lane.
  - Half: be=0011 for addr[1]=0, 1100 for addr[1]=1.
  - Word: be=1111.
  - Loads drive the same be.
- Store data:
  - Byte: wdata[7:0] replicated x4.
  - Half: wdata[15:0] replicated x2.
  - Word: unchanged.
- Load extraction:
  - Byte: mem_rdata[8*lane+7 : 8*lane].
  - Half: upper or lower 16 bits selected by addr[1].
  - Extension: sign-extend by replicating the MSB of the extracted field to bit 31, or zero-extend when req_unsigned=1.
  - Word: unchanged; req_unsigned is ignored.
- Stores leave rdata unchanged.
- mem_ack outside ACCESS is ignored.
- The timeout counter clears on entry to ACCESS.

Test Plan:
- Sign-extended byte load: lb at addr 0x00000003, mem_rdata=0x80FF1234, ack at cycle 1 -> mem_be=1000, done at cycle 2, rdata=0xFFFFFF80, err=0.
- Halfword loads, both extensions:
  - lh at 0x00000002, rdata=0x8001ABCD -> rdata=0xFFFF8001.
  - lhu, same stimulus -> rdata=0x00008001.
  - lh at 0x00000000 with rdata=0x12347FFF -> 0x00007FFF.
- Byte store with wait states: sb at 0x00000005, wdata=0x000000A5, ack after 3 wait cycles -> mem_addr=0x00000004, mem_be=0010, mem_wdata=0xA5A5A5A5, mem_we=1, mem_req high 4 cycles, done at cycle 5.
- Misaligned accesses:
  - lw at 0x00000002 -> mem_req never asserted; done=1, err=1 at cycle 1.
  - lh at 0x00000001 -> same response.
- Timeout: TIMEOUT=4, lw at 0x10 with no ack -> mem_req high cycles 1-4, done=1 and err=1 at cycle 5, rdata equals its previous value.
- Reset mid-access: reset asserted at cycle 2 of an ACCESS -> next cycle mem_req=0, busy=0, no done pulse. A new request afterwards completes normally.
